ring_nic: RTL and testbench
===========================

RING_NIC -- requirements
Module: ring_nic

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning packet and CPU data width.
REQ-002 SHALL have parameter VC_BIT, default 0, meaning the index of the virtual-channel bit inside a packet.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port addr, input, [0:1], CPU register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-006 SHALL have port d_in, input, [0:DATA_W-1], write data from the CPU.
REQ-007 SHALL have port d_out, output, [0:DATA_W-1], registered read data to the CPU.
REQ-008 SHALL have port nicEn, input, 1, CPU access enable.
REQ-009 SHALL have port nicWrEn, input, 1, CPU write enable; it is meaningful only while nicEn=1.
REQ-010 SHALL have port net_si, input, 1, the ring router offers a packet.
REQ-011 SHALL have port net_ri, output, 1, the NIC can accept a packet.
REQ-012 SHALL have port net_di, input, [0:DATA_W-1], inbound packet from the ring.
REQ-013 SHALL have port net_so, output, 1, the NIC injects a packet this cycle.
REQ-014 SHALL have port net_ro, input, 1, the router can accept a packet.
REQ-015 SHALL have port net_do, output, [0:DATA_W-1], outbound packet to the ring.
REQ-016 SHALL have port net_polarity, input, 1, the current ring phase.

Function
REQ-017 SHALL hold a one-entry input buffer (ib, ib_full) and a one-entry output buffer (ob, ob_full).
REQ-018 SHALL drive net_ri = ~ib_full combinationally.
- On net_si & net_ri: capture net_di into ib and set ib_full at the edge.
- net_si while ib_full: ignored; no capture, no error.
REQ-019 SHALL, on a CPU read (nicEn=1, nicWrEn=0), load d_out at the edge with one-cycle latency:
- 00: ib
- 01: status word with bit DATA_W-1 = ib_full, all other bits 0
- 10: ob
- 11: status word with bit DATA_W-1 = ob_full, all other bits 0
REQ-020 SHALL clear ib_full at the edge of an addr-00 read; a read while ib is empty returns stale ib and leaves ib_full at 0.
REQ-021 SHALL hold d_out unchanged in any cycle without a read.
REQ-022 SHALL, on a CPU write (nicEn=1, nicWrEn=1) to addr 10 while ob_full=0, capture d_in into ob and set ob_full.
- Write to 10 while ob_full=1: dropped; ob is unchanged.
- Writes to 00, 01 or 11: ignored.
REQ-023 SHALL drive net_so = ob_full & net_ro & (ob[VC_BIT] == net_polarity) combinationally, and net_do = ob at all times.
REQ-024 SHALL clear ob_full at the edge where net_so=1.
REQ-025 SHALL evaluate a CPU write to 10 in the same cycle as net_so=1 against the pre-edge ob_full, so the write is dropped.
REQ-026 SHALL let inbound and outbound traffic and CPU accesses proceed independently in the same cycle.

Reset
REQ-027 SHALL, on reset assertion and regardless of clk, force ib_full=0, ob_full=0, d_out=0, ib=0 and ob=0.
- Consequently net_ri=1 and net_so=0.
REQ-028 SHALL abandon any in-flight packet when reset is asserted mid-operation, and resume normal operation at the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take the register address codes, status-bit index and VC_BIT default from the shared package ring_nic_pkg.
REQ-030 SHALL instantiate the one-entry buffer sub-module nic_chan_buf twice:
- nic_chan_buf has data, full, load and unload ports.
- One instance is the input channel, one is the output channel.

Verification
REQ-031 SHALL cover inbound delivery:
- Stimulus: net_si=1 with net_di=64'h0000_0000_0000_00AA; next cycle read addr 01; then read addr 00.
- Required: net_ri drops to 0 after capture; status bit 63 = 1; d_out=64'hAA one cycle after the 00 read; then net_ri=1.
REQ-032 SHALL cover backpressure:
- Stimulus: a second net_si while ib_full=1.
- Required: ib keeps its first value; the second packet is not captured.
REQ-033 SHALL cover outbound with polarity:
- Stimulus: write 64'h8000_0000_0000_0055 to addr 10; net_ro=1; net_polarity=0 for 3 cycles, then 1.
- Required: net_so=0 for those 3 cycles, 1 for exactly one cycle after the flip; addr-11 status then reads 0.
REQ-034 SHALL cover the output-full drop:
- Stimulus: two writes to addr 10 with net_ro=0.
- Required: ob keeps the first value; ob_full=1.
REQ-035 SHALL cover the simultaneous case:
- Stimulus: a write to addr 10 in the same cycle net_so=1.
- Required: the write is dropped and ob_full=0 after the edge.
REQ-036 SHALL cover mid-operation reset:
- Stimulus: assert reset between edges while both buffers are full.
- Required: net_ri=1, net_so=0 and d_out=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ring_nic_pkg.sv
// Shared constants for the ring NIC: CPU register map, status-bit placement
// and the default virtual-channel bit position.
package ring_nic_pkg;

  typedef enum logic [1:0] {
    ADDR_IB_DATA = 2'b00,
    ADDR_IB_STAT = 2'b01,
    ADDR_OB_DATA = 2'b10,
    ADDR_OB_STAT = 2'b11
  } nic_addr_t;

  localparam int VC_BIT_DEFAULT = 0;

  // Data buses are numbered [0:W-1]. The full flag sits at index W-1,
  // which is the least significant position of the word.
  function automatic int status_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry packet buffer with a full flag. A load is accepted only while
// the entry is empty; an unload simply releases the entry.
module nic_chan_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:DATA_W-1] load_data,
  input  logic              unload,
  output logic [0:DATA_W-1] data,
  output logic              full
);

  // An empty entry ignores unload, so load wins when both arrive together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (load && !full) begin
      data <= load_data;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_nic.sv
// Ring network interface: one-entry inbound and outbound buffers exposed to
// the CPU through a four-word register window, injecting on phase match.
module ring_nic
  import ring_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int VC_BIT = VC_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic [0:DATA_W-1] ib, ob;
  logic              ib_full, ob_full;
  logic              cpu_rd, cpu_wr;
  logic              ib_unload, ob_load;
  logic [0:DATA_W-1] ib_stat, ob_stat;
  nic_addr_t         reg_sel;

  assign reg_sel = nic_addr_t'(addr);
  assign cpu_rd  = nicEn & ~nicWrEn;
  assign cpu_wr  = nicEn & nicWrEn;

  assign net_ri    = ~ib_full;
  assign ib_unload = cpu_rd & (reg_sel == ADDR_IB_DATA);

  // ob_full is sampled before the edge, so a write racing an injection drops.
  assign ob_load = cpu_wr & (reg_sel == ADDR_OB_DATA) & ~ob_full;
  assign net_so  = ob_full & net_ro & (ob[VC_BIT] == net_polarity);
  assign net_do  = ob;

  nic_chan_buf #(.DATA_W(DATA_W)) u_in_chan (
    .clk       (clk),
    .reset     (reset),
    .load      (net_si),
    .load_data (net_di),
    .unload    (ib_unload),
    .data      (ib),
    .full      (ib_full)
  );

  nic_chan_buf #(.DATA_W(DATA_W)) u_out_chan (
    .clk       (clk),
    .reset     (reset),
    .load      (ob_load),
    .load_data (d_in),
    .unload    (net_so),
    .data      (ob),
    .full      (ob_full)
  );

  always_comb begin
    ib_stat = '0;
    ob_stat = '0;
    ib_stat[status_bit(DATA_W)] = ib_full;
    ob_stat[status_bit(DATA_W)] = ob_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (cpu_rd) begin
      case (reg_sel)
        ADDR_IB_DATA: d_out <= ib;
        ADDR_IB_STAT: d_out <= ib_stat;
        ADDR_OB_DATA: d_out <= ob;
        ADDR_OB_STAT: d_out <= ob_stat;
        default:      d_out <= d_out;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Self-checking bench for ring_nic: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the NIC.
module tb_ring_nic;

  localparam int DW = 64;
  localparam int VC = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:1]    addr;
  logic [0:DW-1] d_in, d_out, net_di, net_do;
  logic          nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: what each buffer holds, whether it is full, and d_out.
  logic [63:0] m_ib, m_ob, m_dout;
  bit          m_ibf, m_obf;
  logic        so_seen;

  ring_nic #(.DATA_W(DW), .VC_BIT(VC)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ib = '0; m_ob = '0; m_dout = '0; m_ibf = 0; m_obf = 0;
  endfunction

  // VC bit counted from the MSB, matching the [0:W-1] numbering of the ports.
  function automatic bit vc_of(input logic [63:0] pkt);
    return pkt[63 - VC];
  endfunction

  // One clock of traffic. Combinational outputs are checked mid-cycle,
  // d_out just after the edge.
  task automatic cyc(input logic en, input logic wr, input logic [1:0] a,
                     input logic [63:0] din, input logic si, input logic [63:0] di,
                     input logic ro, input logic pol);
    bit          e_so, rd, wrt;
    logic [63:0] n_ib, n_ob, n_dout;
    bit          n_ibf, n_obf;
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #2;
    e_so = m_obf && ro && (vc_of(m_ob) == pol);
    check_val("net_ri", 64'(net_ri), 64'(!m_ibf));
    check_val("net_so", 64'(net_so), 64'(e_so));
    check_val("net_do", net_do, m_ob);
    so_seen = net_so;
    rd = en && !wr;
    wrt = en && wr;
    n_ib = m_ib; n_ibf = m_ibf; n_ob = m_ob; n_obf = m_obf; n_dout = m_dout;
    if (rd) begin
      case (a)
        2'b00: n_dout = m_ib;
        2'b01: n_dout = 64'(m_ibf);
        2'b10: n_dout = m_ob;
        default: n_dout = 64'(m_obf);
      endcase
    end
    if (rd && a == 2'b00) n_ibf = 0;
    if (si && !m_ibf) begin n_ib = di; n_ibf = 1; end
    if (e_so) n_obf = 0;
    if (wrt && a == 2'b10 && !m_obf) begin n_ob = din; n_obf = 1; end
    @(posedge clk);
    #1;
    m_ib = n_ib; m_ibf = n_ibf; m_ob = n_ob; m_obf = n_obf; m_dout = n_dout;
    check_val("d_out", d_out, m_dout);
  endtask

  task automatic idle();
    cyc(0, 0, 2'b00, '0, 0, '0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    nicEn = 0; nicWrEn = 0; addr = 2'b00; d_in = '0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
    model_reset();
    #12;
    check_val("rst_d_out", d_out, 64'h0);
    check_val("rst_ri", 64'(net_ri), 64'h1);
    check_val("rst_so", 64'(net_so), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Inbound delivery.
    cyc(0, 0, 2'b00, '0, 1, 64'hAA, 0, 0);
    check_val("ri_after_cap", 64'(net_ri), 64'h0);
    cyc(1, 0, 2'b01, '0, 0, '0, 0, 0);
    check_val("ib_stat_full", d_out, 64'h1);
    cyc(1, 0, 2'b00, '0, 0, '0, 0, 0);
    check_val("ib_data", d_out, 64'hAA);
    check_val("ri_after_rd", 64'(net_ri), 64'h1);

    // Backpressure: second packet must not overwrite the first.
    cyc(0, 0, 2'b00, '0, 1, 64'h11, 0, 0);
    cyc(0, 0, 2'b00, '0, 1, 64'h22, 0, 0);
    cyc(1, 0, 2'b00, '0, 0, '0, 0, 0);
    check_val("ib_backpress", d_out, 64'h11);

    // Outbound waits for the matching ring phase.
    cyc(1, 1, 2'b10, 64'h8000_0000_0000_0055, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'b00, '0, 0, '0, 1, 0);
      check_val("so_wrong_phase", 64'(so_seen), 64'h0);
    end
    cyc(0, 0, 2'b00, '0, 0, '0, 1, 1);
    check_val("so_match", 64'(so_seen), 64'h1);
    cyc(0, 0, 2'b00, '0, 0, '0, 1, 1);
    check_val("so_one_shot", 64'(so_seen), 64'h0);
    cyc(1, 0, 2'b11, '0, 0, '0, 0, 0);
    check_val("ob_stat_empty", d_out, 64'h0);

    // Output-full drop.
    cyc(1, 1, 2'b10, 64'h8000_0000_0000_0001, 0, '0, 0, 0);
    cyc(1, 1, 2'b10, 64'h0000_0000_0000_0777, 0, '0, 0, 0);
    cyc(1, 0, 2'b10, '0, 0, '0, 0, 0);
    check_val("ob_keep_first", d_out, 64'h8000_0000_0000_0001);
    cyc(1, 0, 2'b11, '0, 0, '0, 0, 0);
    check_val("ob_stat_full", d_out, 64'h1);

    // Write racing an injection is dropped.
    cyc(1, 1, 2'b10, 64'h0000_0000_0000_0999, 0, '0, 1, 1);
    check_val("race_so", 64'(so_seen), 64'h1);
    cyc(1, 0, 2'b11, '0, 0, '0, 0, 0);
    check_val("race_ob_empty", d_out, 64'h0);
    cyc(1, 0, 2'b10, '0, 0, '0, 0, 0);
    check_val("race_ob_data", d_out, 64'h8000_0000_0000_0001);

    // Asynchronous reset with both buffers full.
    cyc(0, 0, 2'b00, '0, 1, 64'h1234, 0, 0);
    cyc(1, 1, 2'b10, 64'h0000_0000_0000_0042, 0, '0, 0, 0);
    cyc(1, 0, 2'b01, '0, 0, '0, 0, 0);
    nicEn = 0; net_ro = 1; net_polarity = 0;
    #2;
    check_val("pre_rst_so", 64'(net_so), 64'h1);
    reset = 1'b1;
    #1;
    check_val("async_ri", 64'(net_ri), 64'h1);
    check_val("async_so", 64'(net_so), 64'h0);
    check_val("async_d_out", d_out, 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_ob_empty", net_do, 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
